// File: rtl/sopc_cpu_jtag_cmd_sequencer_pkg.sv
// Shared encodings for the JTAG debug command sequencer: command classes,
// FSM states and the default response timeout.
package sopc_cpu_jtag_cmd_sequencer_pkg;
  localparam logic [1:0] CLS_BREAK    = 2'd0;
  localparam logic [1:0] CLS_OCIMEM   = 2'd1;
  localparam logic [1:0] CLS_TRACEMEM = 2'd2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam int TIMEOUT_DEF = 255;
  localparam int NUM_CLS     = 3;

  // Lowest op letter wins when several strobes of one class fire together.
  function automatic logic [1:0] first_op(input logic [2:0] stb);
    if (stb[0])      return 2'd0;
    else if (stb[1]) return 2'd1;
    else             return 2'd2;
  endfunction
endpackage

// File: rtl/sopc_cpu_jtag_cmd_sequencer_if.sv
// Request strobes, OCI command/response handshake and status of the sequencer.
interface sopc_cpu_jtag_cmd_sequencer_if #(parameter int PAYLOAD_W = 38);
  logic [PAYLOAD_W-1:0] jdo;
  logic                 take_action_break_a, take_action_break_b, take_action_break_c;
  logic                 take_action_ocimem_a, take_action_ocimem_b;
  logic                 take_action_tracemem_a, take_action_tracemem_b;
  logic                 cmd_valid, cmd_ready;
  logic [1:0]           cmd_class, cmd_op;
  logic [PAYLOAD_W-1:0] cmd_payload;
  logic                 rsp_valid;
  logic [31:0]          rsp_data;
  logic [31:0]          MonDReg;
  logic                 monitor_ready, monitor_error, busy, overflow;

  modport master (
    input  jdo, take_action_break_a, take_action_break_b, take_action_break_c,
           take_action_ocimem_a, take_action_ocimem_b,
           take_action_tracemem_a, take_action_tracemem_b,
           cmd_ready, rsp_valid, rsp_data,
    output cmd_valid, cmd_class, cmd_op, cmd_payload, MonDReg,
           monitor_ready, monitor_error, busy, overflow
  );

  modport slave (
    output jdo, take_action_break_a, take_action_break_b, take_action_break_c,
           take_action_ocimem_a, take_action_ocimem_b,
           take_action_tracemem_a, take_action_tracemem_b,
           cmd_ready, rsp_valid, rsp_data,
    input  cmd_valid, cmd_class, cmd_op, cmd_payload, MonDReg,
           monitor_ready, monitor_error, busy, overflow
  );
endinterface

// File: rtl/sopc_cpu_jtag_cmd_slot.sv
// One pending-request slot per command class; o_ovf flags a dropped or
// collided request in the current cycle.
module sopc_cpu_jtag_cmd_slot
  import sopc_cpu_jtag_cmd_sequencer_pkg::*;
#(
  parameter int PAYLOAD_W = 38
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           i_stb,
  input  logic [PAYLOAD_W-1:0] i_jdo,
  input  logic                 i_clr,
  output logic                 o_valid,
  output logic [1:0]           o_op,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_ovf
);
  logic                 r_valid;
  logic [1:0]           r_op;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 w_any, w_multi, w_held;

  assign w_any   = |i_stb;
  assign w_multi = (i_stb[0] & i_stb[1]) | (i_stb[0] & i_stb[2]) | (i_stb[1] & i_stb[2]);
  // A slot being granted this cycle counts as free, so a racing strobe lands cleanly.
  assign w_held  = r_valid & ~i_clr;
  assign o_ovf   = w_any & (w_multi | w_held);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_op      <= '0;
      r_payload <= '0;
    end else if (w_any && !w_held) begin
      r_valid   <= 1'b1;
      r_op      <= first_op(i_stb);
      r_payload <= i_jdo;
    end else if (i_clr) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_op      = r_op;
  assign o_payload = r_payload;
endmodule

// File: rtl/sopc_cpu_jtag_cmd_sequencer.sv
// Arbitrates break/ocimem/tracemem requests onto the shared OCI resource and
// tracks one outstanding command with a response timeout.
module sopc_cpu_jtag_cmd_sequencer
  import sopc_cpu_jtag_cmd_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int PAYLOAD_W      = 38
) (
  input  logic                            clk,
  input  logic                            reset,
  sopc_cpu_jtag_cmd_sequencer_if.master   bus
);
  logic [NUM_CLS-1:0][2:0]           w_stb;
  logic [NUM_CLS-1:0]                w_valid, w_gnt, w_ovf;
  logic [NUM_CLS-1:0][1:0]           w_op;
  logic [NUM_CLS-1:0][PAYLOAD_W-1:0] w_pl;
  logic [1:0]                        w_sel_cls, w_sel_op;
  logic [PAYLOAD_W-1:0]              w_sel_pl;

  logic [1:0]           r_state;
  logic [7:0]           r_cnt;
  logic [1:0]           r_cls, r_op;
  logic [PAYLOAD_W-1:0] r_pl;
  logic [31:0]          r_mon;
  logic                 r_mrdy, r_err, r_ovf;

  assign w_stb[0] = {bus.take_action_break_c, bus.take_action_break_b, bus.take_action_break_a};
  assign w_stb[1] = {1'b0, bus.take_action_ocimem_b, bus.take_action_ocimem_a};
  assign w_stb[2] = {1'b0, bus.take_action_tracemem_b, bus.take_action_tracemem_a};

  for (genvar g = 0; g < NUM_CLS; g++) begin : g_slot
    sopc_cpu_jtag_cmd_slot #(.PAYLOAD_W(PAYLOAD_W)) u_slot (
      .clk      (clk),
      .rst      (reset),
      .i_stb    (w_stb[g]),
      .i_jdo    (bus.jdo),
      .i_clr    (w_gnt[g]),
      .o_valid  (w_valid[g]),
      .o_op     (w_op[g]),
      .o_payload(w_pl[g]),
      .o_ovf    (w_ovf[g])
    );
  end

  // Fixed priority break > ocimem > tracemem, only while idle.
  always_comb begin
    w_gnt     = '0;
    w_sel_cls = CLS_BREAK;
    w_sel_op  = w_op[0];
    w_sel_pl  = w_pl[0];
    if (r_state == ST_IDLE) begin
      if (w_valid[0]) begin
        w_gnt[0] = 1'b1;
      end else if (w_valid[1]) begin
        w_gnt[1]  = 1'b1;
        w_sel_cls = CLS_OCIMEM;
        w_sel_op  = w_op[1];
        w_sel_pl  = w_pl[1];
      end else if (w_valid[2]) begin
        w_gnt[2]  = 1'b1;
        w_sel_cls = CLS_TRACEMEM;
        w_sel_op  = w_op[2];
        w_sel_pl  = w_pl[2];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cls   <= '0;
      r_op    <= '0;
      r_pl    <= '0;
      r_mon   <= '0;
      r_mrdy  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf  <= r_ovf | (|w_ovf);
      r_mrdy <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: if (|w_gnt) begin
          r_cls   <= w_sel_cls;
          r_op    <= w_sel_op;
          r_pl    <= w_sel_pl;
          r_err   <= 1'b0;
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: if (bus.cmd_ready) begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus.rsp_valid) begin
            r_mon   <= bus.rsp_data;
            r_state <= ST_DONE;
          end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_valid     = (r_state == ST_ISSUE);
  assign bus.cmd_class     = r_cls;
  assign bus.cmd_op        = r_op;
  assign bus.cmd_payload   = r_pl;
  assign bus.MonDReg       = r_mon;
  assign bus.monitor_ready = r_mrdy;
  assign bus.monitor_error = r_err;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.overflow      = r_ovf;
endmodule

// File: tb/tb_sopc_cpu_jtag_cmd_sequencer.sv
// Directed bench for the JTAG command sequencer (TIMEOUT_CYCLES = 8).
module tb_sopc_cpu_jtag_cmd_sequencer;
  import sopc_cpu_jtag_cmd_sequencer_pkg::*;
  localparam int PW = 38;

  logic clk = 1'b0;
  logic reset;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sopc_cpu_jtag_cmd_sequencer_if #(.PAYLOAD_W(PW)) bus ();

  sopc_cpu_jtag_cmd_sequencer #(.TIMEOUT_CYCLES(8), .PAYLOAD_W(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stb();
    bus.take_action_break_a    = 1'b0;
    bus.take_action_break_b    = 1'b0;
    bus.take_action_break_c    = 1'b0;
    bus.take_action_ocimem_a   = 1'b0;
    bus.take_action_ocimem_b   = 1'b0;
    bus.take_action_tracemem_a = 1'b0;
    bus.take_action_tracemem_b = 1'b0;
  endtask

  task automatic wait_cmd(input string tag);
    int k = 0;
    while (!bus.cmd_valid && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_cmdv"}, 64'(bus.cmd_valid), 64'd1);
  endtask

  // Wait for the command, check it, accept it, answer one cycle later.
  task automatic serve(input string tag, input logic [1:0] cls, input logic [1:0] op,
                       input logic [PW-1:0] pl, input logic [31:0] d);
    wait_cmd(tag);
    check({tag, "_cls"}, 64'(bus.cmd_class), 64'(cls));
    check({tag, "_op"}, 64'(bus.cmd_op), 64'(op));
    check({tag, "_pl"}, 64'(bus.cmd_payload), 64'(pl));
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = d;
    tick();
    bus.rsp_valid = 1'b0;
    tick();
    check({tag, "_mrdy"}, 64'(bus.monitor_ready), 64'd1);
    check({tag, "_mon"}, 64'(bus.MonDReg), 64'(d));
    tick();
  endtask

  initial begin
    logic [PW-1:0] pl0;
    logic [1:0]    c0, o0;
    bit            stable;
    int            k;

    clr_stb();
    bus.jdo = '0; bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
    reset = 1'b1;
    tick(); tick();
    check("rst_out", 64'({bus.cmd_valid, bus.monitor_ready, bus.monitor_error, bus.busy, bus.overflow}), 64'd0);
    check("rst_mon", 64'(bus.MonDReg), 64'd0);
    check("rst_cmd", 64'({bus.cmd_class, bus.cmd_op, bus.cmd_payload}), 64'd0);
    reset = 1'b0;
    tick();

    // Single ocimem_b with exact latency: cmd_valid at N+2, monitor_ready at N+5.
    bus.jdo = 38'h0_1234_5678; bus.take_action_ocimem_b = 1'b1;
    tick(); clr_stb();
    check("lat_n1_cmdv", 64'(bus.cmd_valid), 64'd0);
    tick();
    check("lat_n2_cmdv", 64'(bus.cmd_valid), 64'd1);
    check("lat_cls", 64'(bus.cmd_class), 64'd1);
    check("lat_op", 64'(bus.cmd_op), 64'd1);
    check("lat_pl", 64'(bus.cmd_payload), 64'h0_1234_5678);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_data = 32'hDEADBEEF;
    check("lat_n3_cmdv", 64'(bus.cmd_valid), 64'd0);
    tick();
    bus.rsp_valid = 1'b0;
    check("lat_n4_mrdy", 64'(bus.monitor_ready), 64'd0);
    check("lat_mon", 64'(bus.MonDReg), 64'hDEADBEEF);
    tick();
    check("lat_n5_mrdy", 64'(bus.monitor_ready), 64'd1);
    check("lat_err", 64'(bus.monitor_error), 64'd0);
    tick();
    check("lat_n6_mrdy", 64'(bus.monitor_ready), 64'd0);

    // Three classes in one cycle: priority order, no overflow.
    bus.jdo = 38'h2A_0000_0001;
    bus.take_action_break_c = 1'b1; bus.take_action_ocimem_a = 1'b1; bus.take_action_tracemem_b = 1'b1;
    tick(); clr_stb();
    serve("pri_brk", CLS_BREAK, 2'd2, 38'h2A_0000_0001, 32'h1111_0001);
    serve("pri_oci", CLS_OCIMEM, 2'd0, 38'h2A_0000_0001, 32'h1111_0002);
    serve("pri_trc", CLS_TRACEMEM, 2'd1, 38'h2A_0000_0001, 32'h1111_0003);
    check("pri_ovf", 64'(bus.overflow), 64'd0);

    // Backpressure: 20 cycles of cmd_ready low; responses in ISSUE are ignored.
    bus.jdo = 38'h15_CAFE_0042; bus.take_action_tracemem_a = 1'b1;
    tick(); clr_stb();
    wait_cmd("bp");
    c0 = bus.cmd_class; o0 = bus.cmd_op; pl0 = bus.cmd_payload;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.cmd_valid || bus.cmd_class !== c0 || bus.cmd_op !== o0 || bus.cmd_payload !== pl0)
        stable = 1'b0;
      bus.rsp_valid = (i == 5); bus.rsp_data = 32'hBAD0_BAD0;
      tick();
    end
    bus.rsp_valid = 1'b0;
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_cls", 64'(c0), 64'd2);
    check("bp_pl", 64'(pl0), 64'h15_CAFE_0042);
    check("bp_mon_ign", 64'(bus.MonDReg), 64'h1111_0003);
    serve("bp_fin", CLS_TRACEMEM, 2'd0, 38'h15_CAFE_0042, 32'h2222_0001);

    // Timeout: error raised after 8 wait cycles, ready the cycle after.
    bus.jdo = 38'h01_0000_00AA; bus.take_action_break_b = 1'b1;
    tick(); clr_stb();
    wait_cmd("to");
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    k = 0;
    while (!bus.monitor_ready && k < 30) begin
      tick();
      k++;
    end
    check("to_lat", 64'(k), 64'd9);
    check("to_err", 64'(bus.monitor_error), 64'd1);
    check("to_mon", 64'(bus.MonDReg), 64'h2222_0001);
    tick();
    bus.jdo = 38'h01_0000_00BB; bus.take_action_ocimem_a = 1'b1;
    tick(); clr_stb();
    tick();
    check("to_clr_cmdv", 64'(bus.cmd_valid), 64'd1);
    check("to_clr_err", 64'(bus.monitor_error), 64'd0);
    serve("to_next", CLS_OCIMEM, 2'd0, 38'h01_0000_00BB, 32'h3333_0001);

    // Asynchronous reset while waiting for the response.
    bus.jdo = 38'h3F_0000_0077; bus.take_action_break_a = 1'b1;
    tick(); clr_stb();
    wait_cmd("ar");
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("ar_out", 64'({bus.cmd_valid, bus.monitor_ready, bus.monitor_error, bus.busy, bus.overflow}), 64'd0);
    check("ar_mon", 64'(bus.MonDReg), 64'd0);
    check("ar_cmd", 64'({bus.cmd_class, bus.cmd_op, bus.cmd_payload}), 64'd0);
    tick();
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.monitor_ready || bus.busy) k++;
      bus.rsp_valid = (i == 2); bus.rsp_data = 32'h4444_0001;
      tick();
    end
    bus.rsp_valid = 1'b0;
    check("ar_no_mrdy", 64'(k), 64'd0);

    // Same-class collision: lowest op letter wins, overflow sticky.
    bus.jdo = 38'h00_5555_0001; bus.take_action_break_a = 1'b1; bus.take_action_break_b = 1'b1;
    tick(); clr_stb();
    check("mul_ovf", 64'(bus.overflow), 64'd1);
    serve("mul", CLS_BREAK, 2'd0, 38'h00_5555_0001, 32'h5555_0001);
    check("mul_ovf_sticky", 64'(bus.overflow), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mul_ovf_rst", 64'(bus.overflow), 64'd0);

    // Strobe in the cycle its slot is granted is accepted without overflow.
    bus.jdo = 38'h00_6666_0001; bus.take_action_break_a = 1'b1;
    tick(); clr_stb();
    bus.jdo = 38'h00_6666_0002; bus.take_action_break_b = 1'b1;
    tick(); clr_stb();
    check("race_ovf", 64'(bus.overflow), 64'd0);
    serve("race1", CLS_BREAK, 2'd0, 38'h00_6666_0001, 32'h6666_0001);
    serve("race2", CLS_BREAK, 2'd1, 38'h00_6666_0002, 32'h6666_0002);

    // Repeated ocimem_a while the first is still pending: extras dropped.
    bus.jdo = 38'h00_7777_0000; bus.take_action_break_a = 1'b1;
    tick(); clr_stb();
    tick();
    for (int i = 1; i <= 3; i++) begin
      bus.jdo = 38'h00_7777_0000 + 38'(i); bus.take_action_ocimem_a = 1'b1;
      tick();
    end
    clr_stb();
    check("drop_ovf", 64'(bus.overflow), 64'd1);
    serve("drop_brk", CLS_BREAK, 2'd0, 38'h00_7777_0000, 32'h7777_0001);
    serve("drop_oci", CLS_OCIMEM, 2'd0, 38'h00_7777_0001, 32'h7777_0002);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_valid) k++;
      tick();
    end
    check("drop_no_more", 64'(k), 64'd0);
    check("drop_ovf_sticky", 64'(bus.overflow), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
